// File: rtl/cache_sa2.sv
// Two-way set-associative, write-back, write-allocate data cache with 128-bit lines.
// Define CACHE_SA2_PERF_CNT_EN to build the saturating hit/miss counters; otherwise both read 0.
module cache_sa2 #(
    parameter int ADDR_W = 30,
    parameter int SETS   = 4,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                proc_reset_n,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic                proc_stall,
    output logic [31:0]         proc_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic [127:0]        mem_rdata,
    input  logic                mem_ready,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t state;

    logic [127:0]     data_q  [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [1:0]       valid_q [SETS];
    logic [1:0]       dirty_q [SETS];
    logic [SETS-1:0]  lru_q;
    logic             victim_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic             req;
    logic             hit0;
    logic             hit1;
    logic             hit;
    logic             hit_way;
    logic             victim_sel;
    logic             victim_dirty;

    assign idx  = proc_addr[IDX_W+1:2];
    assign tag  = proc_addr[ADDR_W-1:IDX_W+2];
    assign word = proc_addr[1:0];
    assign req  = proc_read | proc_write;

    assign hit0    = valid_q[idx][0] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[idx][1] && (tag_q[1][idx] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Invalid ways are filled before anything valid is evicted.
    always_comb begin
        if (!valid_q[idx][0]) begin
            victim_sel = 1'b0;
        end else if (!valid_q[idx][1]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru_q[idx];
        end
    end

    assign victim_dirty = valid_q[idx][victim_sel] && dirty_q[idx][victim_sel];

    // Handshake: mem_read/mem_write stay high, with address and data stable, until the
    // cycle in which mem_ready is sampled; they drop in the following cycle.
    always_comb begin
        proc_stall = 1'b1;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            COMPARE: begin
                proc_stall = req && !hit;
                if (proc_read && !proc_write && hit) begin
                    proc_rdata = data_q[hit_way][idx][{word, 5'b0} +: 32];
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[victim_q][idx], idx};
                mem_wdata = data_q[victim_q][idx];
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                mem_addr = proc_addr[ADDR_W-1:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state    <= IDLE;
            lru_q    <= '0;
            victim_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (req) begin
                        if (hit) begin
                            lru_q[idx] <= ~hit_way;
                            if (proc_write) begin
                                dirty_q[idx][hit_way] <= 1'b1;
                            end
                        end else begin
                            victim_q <= victim_sel;
                            state    <= victim_dirty ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        dirty_q[idx][victim_q] <= 1'b0;
                        state                  <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        state                  <= COMPARE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line data and tags carry no reset; the valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (state == COMPARE && proc_write && hit) begin
            data_q[hit_way][idx][{word, 5'b0} +: 32] <= proc_wdata;
        end
        if (state == ALLOCATE && mem_ready) begin
            data_q[victim_q][idx] <= mem_rdata;
            tag_q[victim_q][idx]  <= tag;
        end
    end

`ifdef CACHE_SA2_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             refill_q;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] miss_q;

    // refill_q marks the completing hit after a line fill so it is not counted as a hit.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            if (state == ALLOCATE && mem_ready) begin
                refill_q <= 1'b1;
            end else if (state == COMPARE) begin
                refill_q <= 1'b0;
            end
            if (state == COMPARE && req) begin
                if (!hit && miss_q != '1) begin
                    miss_q <= miss_q + CNT_ONE;
                end
                if (hit && !refill_q && hit_q != '1) begin
                    hit_q <= hit_q + CNT_ONE;
                end
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    a_no_dual_request: assert property (@(posedge clk) disable iff (!proc_reset_n)
        !(mem_read && mem_write));

    a_single_way_hit: assert property (@(posedge clk) disable iff (!proc_reset_n)
        !(hit0 && hit1));

endmodule

// File: tb/tb_cache_sa2.sv
// Bench for cache_sa2: table-driven access sequence on a 4-set cache, reset corner cases,
// and a short LRU sequence on an 8-set, 20-bit-address instance.
`timescale 1ns/1ps
module tb_cache_sa2;
    localparam int MEM_LAT   = 3;
    localparam int STALL_MAX = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic proc_reset_n;

    // ---------------- 4-set instance ----------------
    logic         proc_read, proc_write, proc_stall;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [31:0]  hit_cnt, miss_cnt;

    cache_sa2 #(.ADDR_W(30), .SETS(4), .CNT_W(32)) u_dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // ---------------- 8-set, 20-bit instance ----------------
    logic         proc_read_8, proc_write_8, proc_stall_8;
    logic [19:0]  proc_addr_8;
    logic [31:0]  proc_wdata_8, proc_rdata_8;
    logic         mem_read_8, mem_write_8, mem_ready_8;
    logic [17:0]  mem_addr_8;
    logic [127:0] mem_wdata_8, mem_rdata_8;
    logic [31:0]  hit_cnt_8, miss_cnt_8;

    cache_sa2 #(.ADDR_W(20), .SETS(8), .CNT_W(32)) u_dut8 (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .proc_read(proc_read_8), .proc_write(proc_write_8), .proc_addr(proc_addr_8),
        .proc_wdata(proc_wdata_8), .proc_stall(proc_stall_8), .proc_rdata(proc_rdata_8),
        .mem_read(mem_read_8), .mem_write(mem_write_8), .mem_addr(mem_addr_8),
        .mem_wdata(mem_wdata_8), .mem_rdata(mem_rdata_8), .mem_ready(mem_ready_8),
        .hit_cnt(hit_cnt_8), .miss_cnt(miss_cnt_8)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic [127:0] line_mem [logic [27:0]];
    logic [31:0]  ref_mem  [logic [29:0]];

    function automatic logic [31:0] pat(input logic [29:0] a);
        return 32'hA500_0000 | {8'h00, a[23:0]};
    endfunction

    function automatic logic [31:0] pat8(input logic [19:0] a);
        return 32'hB600_0000 | {12'h000, a};
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] l);
        logic [127:0] v;
        if (line_mem.exists(l)) return line_mem[l];
        for (int k = 0; k < 4; k++) v[32*k +: 32] = pat({l, 2'(k)});
        return v;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- memory responders ----------------
    int           mem_cnt, rd_total, wr_total;
    logic [27:0]  last_rd_addr, last_wr_addr;
    logic [127:0] last_wr_data;
    bit           both_high;

    initial begin
        mem_ready = 1'b0; mem_rdata = '0; mem_cnt = 0; rd_total = 0; wr_total = 0;
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0; both_high = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
            if (mem_read && mem_write) both_high = 1'b1;
            if (mem_read || mem_write) begin
                mem_cnt++;
                if (mem_read) begin rd_total++; last_rd_addr = mem_addr; end
                if (mem_write) begin wr_total++; last_wr_addr = mem_addr; last_wr_data = mem_wdata; end
                if (mem_cnt >= MEM_LAT) begin
                    mem_ready = 1'b1;
                    mem_cnt   = 0;
                    if (mem_write) line_mem[mem_addr] = mem_wdata;
                    else           mem_rdata = mem_line(mem_addr);
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    bit wr8_seen;
    initial begin
        mem_ready_8 = 1'b0; mem_rdata_8 = '0; wr8_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_write_8) wr8_seen = 1'b1;
            if (mem_ready_8) begin
                mem_ready_8 = 1'b0;
                mem_rdata_8 = '0;
            end else if (mem_read_8) begin
                mem_ready_8 = 1'b1;
                for (int k = 0; k < 4; k++) mem_rdata_8[32*k +: 32] = pat8({mem_addr_8, 2'(k)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, output int stalls);
        logic [31:0] got;
        @(negedge clk);
        proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
        if (rd && !wr) exp_q.push_back(ref_read(a));
        if (wr) ref_mem[a] = wd;
        stalls = 0;
        #1;
        while (proc_stall && stalls <= STALL_MAX) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls > STALL_MAX) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, stalls);
            exp_q.delete();
        end else if (rd && !wr) begin
            got = proc_rdata;
            check($sformatf("rdata@%0h", a), 128'(got), 128'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    task automatic access8(input logic [19:0] a, output int stalls);
        logic [31:0] got;
        @(negedge clk);
        proc_read_8 = 1'b1; proc_addr_8 = a;
        exp_q.push_back(pat8(a));
        stalls = 0;
        #1;
        while (proc_stall_8 && stalls <= STALL_MAX) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls > STALL_MAX) begin
            checks++; errors++;
            $display("FAIL access8_timeout: addr %0h still stalled after %0d cycles", a, stalls);
            exp_q.delete();
        end else begin
            got = proc_rdata_8;
            check($sformatf("rdata8@%0h", a), 128'(got), 128'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        proc_read_8 = 1'b0;
    endtask

    // ---------------- stimulus tables ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          stalls;
        int          fills;
        logic [27:0] fill_addr;
        int          wbs;
        logic [27:0] wb_addr;
    } vec_t;

    typedef struct {
        logic [19:0] addr;
        int          stalls;
    } vec8_t;

    vec_t  vecs  [16];
    vec8_t vecs8 [7];

    initial begin : main
        int st, rd0, wr0, n_hit, n_miss, n_hit8, n_miss8;
        logic [127:0] exp_line;
        logic [31:0] exp_hits, exp_miss;

        proc_reset_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
        proc_read_8 = 1'b0; proc_write_8 = 1'b0; proc_addr_8 = '0; proc_wdata_8 = '0;

        line_mem[28'h4] = 128'h44443333_22221111_00000000_DEADBEEF;
        ref_mem[30'h10] = 32'hDEADBEEF;
        ref_mem[30'h11] = 32'h00000000;
        ref_mem[30'h12] = 32'h22221111;
        ref_mem[30'h13] = 32'h44443333;

        //          rd wr addr       wdata          st fl fill     wb wb_addr
        vecs[0]  = '{1, 0, 30'h10,  32'h0,         4, 1, 28'h4,  0, 28'h0};
        vecs[1]  = '{0, 1, 30'h11,  32'hCAFEF00D,  0, 0, 28'h0,  0, 28'h0};
        vecs[2]  = '{1, 0, 30'h11,  32'h0,         0, 0, 28'h0,  0, 28'h0};
        vecs[3]  = '{1, 0, 30'h50,  32'h0,         4, 1, 28'h14, 0, 28'h0};
        vecs[4]  = '{1, 0, 30'h50,  32'h0,         0, 0, 28'h0,  0, 28'h0};
        vecs[5]  = '{1, 0, 30'h90,  32'h0,         7, 1, 28'h24, 1, 28'h4};
        vecs[6]  = '{1, 0, 30'h50,  32'h0,         0, 0, 28'h0,  0, 28'h0};
        vecs[7]  = '{1, 0, 30'h11,  32'h0,         4, 1, 28'h4,  0, 28'h0};
        vecs[8]  = '{0, 1, 30'h25,  32'h12345678,  4, 1, 28'h9,  0, 28'h0};
        vecs[9]  = '{1, 0, 30'h25,  32'h0,         0, 0, 28'h0,  0, 28'h0};
        vecs[10] = '{1, 0, 30'h24,  32'h0,         0, 0, 28'h0,  0, 28'h0};
        vecs[11] = '{1, 1, 30'h26,  32'h0BADC0DE,  0, 0, 28'h0,  0, 28'h0};
        vecs[12] = '{1, 0, 30'h26,  32'h0,         0, 0, 28'h0,  0, 28'h0};
        vecs[13] = '{1, 0, 30'hD5,  32'h0,         4, 1, 28'h35, 0, 28'h0};
        vecs[14] = '{1, 0, 30'h115, 32'h0,         7, 1, 28'h45, 1, 28'h9};
        vecs[15] = '{1, 0, 30'h26,  32'h0,         4, 1, 28'h9,  0, 28'h0};

        vecs8[0] = '{20'h00, 2};
        vecs8[1] = '{20'h20, 2};
        vecs8[2] = '{20'h00, 0};
        vecs8[3] = '{20'h20, 0};
        vecs8[4] = '{20'h40, 2};
        vecs8[5] = '{20'h20, 0};
        vecs8[6] = '{20'h00, 2};

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_proc_stall", 128'(proc_stall), 128'(1));
        check("rst_proc_rdata", 128'(proc_rdata), 128'(0));
        check("rst_mem_read",   128'(mem_read),   128'(0));
        check("rst_mem_write",  128'(mem_write),  128'(0));
        check("rst_mem_addr",   128'(mem_addr),   128'(0));
        check("rst_mem_wdata",  mem_wdata,        128'(0));
        check("rst_hit_cnt",    128'(hit_cnt),    128'(0));
        check("rst_miss_cnt",   128'(miss_cnt),   128'(0));

        // One IDLE cycle, then COMPARE with no request is unstalled.
        proc_reset_n = 1'b1;
        #1 check("idle_stall", 128'(proc_stall), 128'(1));
        @(posedge clk);
        #1 check("compare_idle_stall", 128'(proc_stall), 128'(0));

        n_hit = 0; n_miss = 0;
        for (int i = 0; i < 16; i++) begin
            rd0 = rd_total; wr0 = wr_total;
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st);
            check($sformatf("v%0d_stalls", i), 128'(st), 128'(vecs[i].stalls));
            check($sformatf("v%0d_read_cycles", i), 128'(rd_total - rd0), 128'(vecs[i].fills * MEM_LAT));
            check($sformatf("v%0d_write_cycles", i), 128'(wr_total - wr0), 128'(vecs[i].wbs * MEM_LAT));
            if (vecs[i].fills > 0)
                check($sformatf("v%0d_fill_addr", i), 128'(last_rd_addr), 128'(vecs[i].fill_addr));
            if (vecs[i].wbs > 0) begin
                check($sformatf("v%0d_wb_addr", i), 128'(last_wr_addr), 128'(vecs[i].wb_addr));
                for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = ref_read({vecs[i].wb_addr, 2'(k)});
                check($sformatf("v%0d_wb_line", i), last_wr_data, exp_line);
            end
            if (vecs[i].stalls == 0) n_hit++;
            else n_miss++;
        end

`ifdef CACHE_SA2_PERF_CNT_EN
        exp_hits = 32'(n_hit); exp_miss = 32'(n_miss);
`else
        exp_hits = 32'd0; exp_miss = 32'd0;
`endif
        check("hit_cnt", 128'(hit_cnt), 128'(exp_hits));
        check("miss_cnt", 128'(miss_cnt), 128'(exp_miss));

        // Reset asserted mid-ALLOCATE drops mem_read before any clock edge.
        @(negedge clk);
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h200;
        @(negedge clk);
        @(negedge clk);
        #1 check("mid_alloc_mem_read", 128'(mem_read), 128'(1));
        #1 proc_reset_n = 1'b0;
        #1 check("async_reset_mem_read", 128'(mem_read), 128'(0));
        check("async_reset_stall", 128'(proc_stall), 128'(1));
        proc_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst2_hit_cnt", 128'(hit_cnt), 128'(0));
        check("rst2_miss_cnt", 128'(miss_cnt), 128'(0));
        proc_reset_n = 1'b1;
        rd0 = rd_total;
        access(1'b1, 1'b0, 30'h10, 32'h0, st);
        check("post_reset_miss_stalls", 128'(st), 128'(4));
        check("post_reset_fill_cycles", 128'(rd_total - rd0), 128'(MEM_LAT));

        // 8-set instance: two tags share set 0, a third evicts the LRU way.
        n_hit8 = 0; n_miss8 = 0;
        for (int i = 0; i < 7; i++) begin
            access8(vecs8[i].addr, st);
            check($sformatf("s8_v%0d_stalls", i), 128'(st), 128'(vecs8[i].stalls));
            if (vecs8[i].stalls == 0) n_hit8++;
            else n_miss8++;
        end
`ifdef CACHE_SA2_PERF_CNT_EN
        exp_hits = 32'(n_hit8); exp_miss = 32'(n_miss8);
`else
        exp_hits = 32'd0; exp_miss = 32'd0;
`endif
        check("s8_hit_cnt", 128'(hit_cnt_8), 128'(exp_hits));
        check("s8_miss_cnt", 128'(miss_cnt_8), 128'(exp_miss));
        check("s8_no_writeback", 128'(wr8_seen), 128'(0));
        check("no_dual_request", 128'(both_high), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
